raw12_depack: RTL and testbench
===============================

// Module: raw12_depack
// PURPOSE
//  Unpacks the CSI-2 RAW12 byte stream (2 lanes, 16 bits/beat) into 24-bit pixel pairs.
//  Sits between the CSI-2 packet/lane aligner and the Bayer demosaic stage (raw2rgb).
//  One packed 3-byte group becomes one pair word. Emits exactly LINE_LENGTH pair words per line.
// PARAMETERS
//  LINE_LENGTH  640  pixel-pair words per line; must be even (input = LINE_LENGTH*3/2 beats)
// PORTS
//  clk         in   1   pixel-domain clock
//  rst_n       in   1   reset, asynchronous, active-low
//  byte_in     in   16  two payload bytes; [7:0] = earlier byte (lane0), [15:8] = later (lane1)
//  byte_valid  in   1   byte_in carries payload this cycle
//  line_start  in   1   1-cycle pulse: start of long packet (new line)
//  pix_out     out  24  pair word: [23:12] = earlier pixel, [11:0] = later pixel
//  pix_valid   out  1   pix_out valid, 1-cycle pulse per pair
//  line_done   out  1   pulse coincident with last (LINE_LENGTH-th) pix_valid of a line
//  err_short   out  1   pulse: line_start arrived before previous line completed
// BEHAVIOUR
//  Reset: state IDLE, phase 0, pair count 0, byte regs 0, all outputs 0.
//  States
//  - IDLE: beats are dropped.
//  - ACTIVE: beats are unpacked.
//  - IDLE->ACTIVE on line_start.
//  - ACTIVE->IDLE when the pair count reaches LINE_LENGTH.
//  Phase counter 0->1->2->0, advanced only on accepted beats (byte_valid=1 in ACTIVE).
//  Beat bytes per 3-beat cycle are b0..b5.
//  - Phase 0 (b0,b1): store both, no output.
//  - Phase 1 (b2,b3): emit {b0,b2[3:0], b1,b2[7:4]}; store b3.
//  - Phase 2 (b4,b5): emit {b3,b5[3:0], b4,b5[7:4]}.
//  Latency: pix_out/pix_valid registered, valid the cycle after the completing beat.
//  pix_out holds its last value when pix_valid=0.
//  Pair counter width is $clog2(LINE_LENGTH+1); it increments per emitted pair.
//  When the LINE_LENGTH-th pair is emitted:
//  - line_done pulses with that pix_valid.
//  - The counter and phase clear, and the state goes to IDLE.
//  - Excess beats before the next line_start are dropped silently.
//  line_start in ACTIVE with count!=0 or phase!=0:
//  - err_short pulses for 1 cycle.
//  - Count and phase clear; the state stays ACTIVE (new line). No partial pair is emitted.
//  line_start in ACTIVE with count=0 and phase=0: restart only, no error.
//  line_start and byte_valid in the same cycle: that beat is phase-0 of the new line.
//  byte_valid gaps (0 between beats) are allowed anywhere; state and phase hold.
//  Async rst_n assertion mid-line: immediate return to reset values; the partial line is lost.
// TESTING
//  1. line_start; beats 16'h3412, 16'hBCA5, 16'h9F56 -> pix_out 24'h12534A, then 24'hBCF569.
//     Each pix_valid is 1 cycle after its beat.
//  2. LINE_LENGTH=4, 6 beats with byte_valid toggling 1/0 -> 4 pix_valid.
//     line_done with the 4th; a 7th beat produces nothing.
//  3. line_start after 2 beats (phase 2) -> err_short pulse, no pix_valid.
//     A following full line is unpacked correctly.
//  4. line_start coincident with the first byte_valid -> first pair correct.
//     No err_short from the idle state.
//  5. byte_valid without a preceding line_start after reset -> no outputs, state IDLE.
//  6. rst_n low mid-line (after 1 beat), released -> all outputs 0.
//     The next line starts at phase 0 with no stale bytes.

Source files
------------

// File: rtl/raw12_depack.sv
// CSI-2 RAW12 depacker: 2-lane 16-bit byte beats in, 24-bit pixel pairs out.
// One 3-byte group per pair; a line ends after LINE_LENGTH pairs.
module raw12_depack #(
    parameter int LINE_LENGTH = 640
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] byte_in,
    input  logic        byte_valid,
    input  logic        line_start,
    output logic [23:0] pix_out,
    output logic        pix_valid,
    output logic        line_done,
    output logic        err_short
);

    localparam int CW = $clog2(LINE_LENGTH + 1);
    localparam logic [CW-1:0] LAST_M1 = CW'(LINE_LENGTH - 1);

    localparam logic ST_IDLE   = 1'b0;
    localparam logic ST_ACTIVE = 1'b1;

    localparam logic [1:0] PH_0 = 2'd0;
    localparam logic [1:0] PH_1 = 2'd1;
    localparam logic [1:0] PH_2 = 2'd2;

    logic          state_q, state_d;
    logic [1:0]    phase_q, phase_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    b0_q, b0_d;
    logic [7:0]    b1_q, b1_d;
    logic [7:0]    b3_q, b3_d;
    logic [23:0]   pix_q, pix_d;
    logic          pix_valid_q, pix_valid_d;
    logic          line_done_q, line_done_d;
    logic          err_short_q, err_short_d;

    logic [1:0]    cur_phase;
    logic [CW-1:0] cur_cnt;
    logic          live;
    logic          emit;
    logic [23:0]   pair;

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        cnt_d       = cnt_q;
        b0_d        = b0_q;
        b1_d        = b1_q;
        b3_d        = b3_q;
        pix_d       = pix_q;
        pix_valid_d = 1'b0;
        line_done_d = 1'b0;
        err_short_d = 1'b0;
        cur_phase   = phase_q;
        cur_cnt     = cnt_q;
        live        = (state_q == ST_ACTIVE);
        emit        = 1'b0;
        pair        = 24'd0;

        // A new line discards any partial progress; the same-cycle beat is phase 0.
        if (line_start) begin
            err_short_d = live && ((cnt_q != '0) || (phase_q != PH_0));
            cur_phase   = PH_0;
            cur_cnt     = '0;
            live        = 1'b1;
            state_d     = ST_ACTIVE;
        end

        phase_d = cur_phase;
        cnt_d   = cur_cnt;

        if (live && byte_valid) begin
            case (cur_phase)
                PH_0: begin
                    b0_d    = byte_in[7:0];
                    b1_d    = byte_in[15:8];
                    phase_d = PH_1;
                end
                PH_1: begin
                    pair    = {b0_q, byte_in[3:0], b1_q, byte_in[7:4]};
                    b3_d    = byte_in[15:8];
                    emit    = 1'b1;
                    phase_d = PH_2;
                end
                PH_2: begin
                    pair    = {b3_q, byte_in[11:8], byte_in[7:0], byte_in[15:12]};
                    emit    = 1'b1;
                    phase_d = PH_0;
                end
                default: phase_d = PH_0;
            endcase
        end

        if (emit) begin
            pix_d       = pair;
            pix_valid_d = 1'b1;
            if (cur_cnt == LAST_M1) begin
                line_done_d = 1'b1;
                cnt_d       = '0;
                phase_d     = PH_0;
                state_d     = ST_IDLE;
            end else begin
                cnt_d = cur_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            phase_q     <= PH_0;
            cnt_q       <= '0;
            b0_q        <= 8'd0;
            b1_q        <= 8'd0;
            b3_q        <= 8'd0;
            pix_q       <= 24'd0;
            pix_valid_q <= 1'b0;
            line_done_q <= 1'b0;
            err_short_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            cnt_q       <= cnt_d;
            b0_q        <= b0_d;
            b1_q        <= b1_d;
            b3_q        <= b3_d;
            pix_q       <= pix_d;
            pix_valid_q <= pix_valid_d;
            line_done_q <= line_done_d;
            err_short_q <= err_short_d;
        end
    end

    assign pix_out   = pix_q;
    assign pix_valid = pix_valid_q;
    assign line_done = line_done_q;
    assign err_short = err_short_q;

endmodule

// File: tb/tb_raw12_depack.sv
// Bench for raw12_depack: byte-queue reference model feeding a scoreboard
// that a free-running monitor drains against the DUT outputs.
module tb_raw12_depack;

    localparam int L = 4;

    logic        clk;
    logic        rst_n;
    logic [15:0] byte_in;
    logic        byte_valid;
    logic        line_start;
    logic [23:0] pix_out;
    logic        pix_valid;
    logic        line_done;
    logic        err_short;

    raw12_depack #(.LINE_LENGTH(L)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .line_start (line_start),
        .pix_out    (pix_out),
        .pix_valid  (pix_valid),
        .line_done  (line_done),
        .err_short  (err_short)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [23:0] pix;
        logic        done;
        int          at;
    } exp_t;

    exp_t        eq[$];
    int          errq[$];
    exp_t        mon_e;
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [23:0] last_pix = 24'd0;

    // Reference model: a line is a byte stream; every 3 bytes make one pair.
    bit          m_active = 1'b0;
    logic [7:0]  m_bytes[$];
    int          m_cnt = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    task automatic beat(input logic ls, input logic bv, input logic [15:0] d);
        logic [7:0]  x0, x1, x2;
        logic [23:0] p;
        bit          dn;
        @(posedge clk);
        #1;
        line_start = ls;
        byte_valid = bv;
        byte_in    = d;
        if (ls) begin
            if (m_active && (m_cnt != 0 || m_bytes.size() != 0))
                errq.push_back(cyc + 1);
            m_active = 1'b1;
            m_bytes.delete();
            m_cnt = 0;
        end
        if (bv && m_active) begin
            m_bytes.push_back(d[7:0]);
            m_bytes.push_back(d[15:8]);
            if (m_bytes.size() >= 3) begin
                x0 = m_bytes.pop_front();
                x1 = m_bytes.pop_front();
                x2 = m_bytes.pop_front();
                p  = {x0, x2[3:0], x1, x2[7:4]};
                m_cnt++;
                dn = (m_cnt == L);
                eq.push_back('{p, dn, cyc + 1});
                if (dn) begin
                    m_active = 1'b0;
                    m_bytes.delete();
                    m_cnt = 0;
                end
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) beat(1'b0, 1'b0, 16'($urandom));
    endtask

    task automatic full_line(input bit gaps);
        beat(1'b1, 1'b0, 16'h0);
        for (int i = 0; i < L * 3 / 2; i++) begin
            beat(1'b0, 1'b1, 16'($urandom));
            if (gaps) beat(1'b0, 1'b0, 16'($urandom));
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n      = 1'b0;
        line_start = 1'b0;
        byte_valid = 1'b0;
        m_active   = 1'b0;
        m_bytes.delete();
        m_cnt      = 0;
        eq.delete();
        errq.delete();
        last_pix   = 24'd0;
        #1;
        chk("rst_pix_out", 32'(pix_out), 32'h0);
        chk("rst_pix_valid", 32'(pix_valid), 32'h0);
        chk("rst_line_done", 32'(line_done), 32'h0);
        chk("rst_err_short", 32'(err_short), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    always @(posedge clk) begin
        #2;
        if (pix_valid) begin
            if (eq.size() == 0) begin
                chk("unexpected_pix_valid", 32'h1, 32'h0);
            end else begin
                mon_e = eq.pop_front();
                chk("pix_out", 32'(pix_out), 32'(mon_e.pix));
                chk("line_done", 32'(line_done), 32'(mon_e.done));
                chk("pix_latency", 32'(cyc), 32'(mon_e.at));
                last_pix = mon_e.pix;
            end
        end else begin
            chk("pix_hold", 32'(pix_out), 32'(last_pix));
            chk("line_done_alone", 32'(line_done), 32'h0);
        end
        if (err_short) begin
            if (errq.size() == 0)
                chk("unexpected_err_short", 32'h1, 32'h0);
            else
                chk("err_short_cycle", 32'(cyc), 32'(errq.pop_front()));
        end
    end

    initial begin
        rst_n      = 1'b0;
        line_start = 1'b0;
        byte_valid = 1'b0;
        byte_in    = 16'h0;
        #2;
        chk("init_pix_out", 32'(pix_out), 32'h0);
        chk("init_pix_valid", 32'(pix_valid), 32'h0);
        chk("init_line_done", 32'(line_done), 32'h0);
        chk("init_err_short", 32'(err_short), 32'h0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Stray beats before any line_start are dropped.
        for (int i = 0; i < 5; i++) beat(1'b0, 1'b1, 16'($urandom));
        idle(2);

        // Known vector, then finish the line and push an excess beat.
        beat(1'b1, 1'b0, 16'h0);
        beat(1'b0, 1'b1, 16'h3412);
        beat(1'b0, 1'b1, 16'hBCA5);
        beat(1'b0, 1'b1, 16'h9F56);
        for (int i = 0; i < 3; i++) beat(1'b0, 1'b1, 16'($urandom));
        beat(1'b0, 1'b1, 16'hFFFF);
        idle(2);

        // Line with valid toggling every beat.
        full_line(1'b1);
        beat(1'b0, 1'b1, 16'h1234);
        idle(2);

        // Short line aborted at phase 2, followed by a complete line.
        beat(1'b1, 1'b0, 16'h0);
        beat(1'b0, 1'b1, 16'($urandom));
        beat(1'b0, 1'b1, 16'($urandom));
        full_line(1'b0);
        idle(2);

        // line_start coincident with the first beat, from idle.
        beat(1'b1, 1'b1, 16'h3412);
        beat(1'b0, 1'b1, 16'hBCA5);
        for (int i = 0; i < 4; i++) beat(1'b0, 1'b1, 16'($urandom));
        idle(2);

        // Restart on an untouched line: no error.
        beat(1'b1, 1'b0, 16'h0);
        beat(1'b1, 1'b0, 16'h0);
        for (int i = 0; i < 6; i++) beat(1'b0, 1'b1, 16'($urandom));
        idle(2);

        // Reset mid-line after one beat; next line must start clean.
        beat(1'b1, 1'b0, 16'h0);
        beat(1'b0, 1'b1, 16'hAAAA);
        do_reset();
        for (int i = 0; i < 3; i++) beat(1'b0, 1'b1, 16'($urandom));
        full_line(1'b0);
        idle(2);

        // Randomized traffic.
        for (int i = 0; i < 800; i++)
            beat(($urandom_range(0, 24) == 0), ($urandom_range(0, 9) < 7),
                 16'($urandom));
        idle(4);

        chk("scoreboard_drained", 32'(eq.size()), 32'h0);
        chk("err_queue_drained", 32'(errq.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
